// File: rtl/prnhead_shift_out.sv
// Printhead shift-out: fetches 16-bit words, shifts four lane nibbles MSB-first under head_clk,
// then latches the line. Optional abort on converter data_error via PRNHEAD_ERR_ABORT_EN.
module prnhead_shift_out #(
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned LATCH_LEN = 8
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        line_start,
    input  logic [15:0] line_words,
    output logic        rd_req,
    input  logic [15:0] Prn_Data,
    input  logic        data_error,
    output logic        head_clk,
    output logic [3:0]  head_sdi,
    output logic        head_lat,
    output logic        busy,
    output logic        line_done,
    output logic        line_abort
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StWait,
        StShift,
        StLatch,
        StDone
    } state_e;

    localparam logic [7:0] PhaseReload = 8'(CLK_DIV - 1);
    localparam logic [7:0] LatchReload = 8'(LATCH_LEN - 1);

    state_e      state_q;
    logic [15:0] sreg_q;
    logic [1:0]  idx_q;
    logic [7:0]  phase_q;
    logic [15:0] words_q;
    logic        abort_req;

    // Lane k takes bit idx of nibble k.
    function automatic logic [3:0] lane_bits(input logic [15:0] word, input logic [1:0] idx);
        logic [15:0] shifted;
        shifted = word >> idx;
        return {shifted[12], shifted[8], shifted[4], shifted[0]};
    endfunction

`ifdef PRNHEAD_ERR_ABORT_EN
    assign abort_req = busy & data_error;
`else
    logic unused_data_error;
    assign unused_data_error = data_error;
    assign abort_req         = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= StIdle;
            sreg_q     <= '0;
            idx_q      <= '0;
            phase_q    <= '0;
            words_q    <= '0;
            rd_req     <= 1'b0;
            head_clk   <= 1'b0;
            head_sdi   <= '0;
            head_lat   <= 1'b0;
            busy       <= 1'b0;
            line_done  <= 1'b0;
            line_abort <= 1'b0;
        end else if (abort_req) begin
            state_q    <= StIdle;
            rd_req     <= 1'b0;
            head_clk   <= 1'b0;
            head_sdi   <= '0;
            head_lat   <= 1'b0;
            busy       <= 1'b0;
            line_done  <= 1'b0;
            line_abort <= 1'b1;
        end else begin
            line_abort <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    line_done <= 1'b0;
                    if (line_start) begin
                        if (line_words != 16'd0) begin
                            words_q <= line_words;
                            busy    <= 1'b1;
                            rd_req  <= 1'b1;
                            state_q <= StFetch;
                        end else begin
                            // Empty line: report completion without touching the head.
                            line_done <= 1'b1;
                            state_q   <= StDone;
                        end
                    end
                end
                StFetch: begin
                    rd_req  <= 1'b0;
                    state_q <= StWait;
                end
                StWait: begin
                    sreg_q   <= Prn_Data;
                    idx_q    <= 2'd3;
                    head_sdi <= lane_bits(Prn_Data, 2'd3);
                    head_clk <= 1'b0;
                    phase_q  <= PhaseReload;
                    state_q  <= StShift;
                end
                StShift: begin
                    if (phase_q != 8'd0) begin
                        phase_q <= phase_q - 8'd1;
                    end else if (!head_clk) begin
                        head_clk <= 1'b1;
                        phase_q  <= PhaseReload;
                    end else begin
                        head_clk <= 1'b0;
                        phase_q  <= PhaseReload;
                        if (idx_q != 2'd0) begin
                            idx_q    <= idx_q - 2'd1;
                            head_sdi <= lane_bits(sreg_q, idx_q - 2'd1);
                        end else begin
                            head_sdi <= '0;
                            words_q  <= words_q - 16'd1;
                            if (words_q == 16'd1) begin
                                state_q <= StLatch;
                            end else begin
                                rd_req  <= 1'b1;
                                state_q <= StFetch;
                            end
                        end
                    end
                end
                StLatch: begin
                    // First CLK_DIV cycles are setup with the head idle, then the latch pulse.
                    if (phase_q != 8'd0) begin
                        phase_q <= phase_q - 8'd1;
                    end else if (!head_lat) begin
                        head_lat <= 1'b1;
                        phase_q  <= LatchReload;
                    end else begin
                        head_lat  <= 1'b0;
                        line_done <= 1'b1;
                        busy      <= 1'b0;
                        state_q   <= StDone;
                    end
                end
                StDone: begin
                    line_done <= 1'b0;
                    state_q   <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
